// File: rtl/dsp_frame_sequencer_pkg.sv
// Shared types and constants for the dsp frame sequencer.
// Default widths, counter width and the dsp read latency live here.
package dsp_frame_sequencer_pkg;

    localparam int BUS_WIDTH_DEF = 24;
    localparam int SLOTS_DEF     = 2;
    localparam int PARAM_W_DEF   = 8;
    localparam int CNT_W         = $clog2(SLOTS_DEF + 1);

    // Cycles from a dsp_param change to a valid dsp_dout; ADDR plus WAITD cover them.
    localparam int DSP_READ_LAT  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        ADDR,
        WAITD,
        OUT
    } state_t;

endpackage

// File: rtl/dsp_frame_sequencer_if.sv
// Frame control, upstream/downstream valid-ready and dsp-side signals of the sequencer.
// "master" is the sequencer's view; "slave" is the view of the surrounding logic.
interface dsp_frame_sequencer_if
    import dsp_frame_sequencer_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int PARAM_W   = PARAM_W_DEF
);

    logic                 start;
    logic                 busy;
    logic                 done;

    logic                 s_valid;
    logic                 s_ready;
    logic [BUS_WIDTH-1:0] s_data;

    logic [BUS_WIDTH-1:0] dsp_din;
    logic                 dsp_we;
    logic [PARAM_W-1:0]   dsp_param;
    logic [BUS_WIDTH-1:0] dsp_dout;

    logic                 m_valid;
    logic                 m_ready;
    logic [BUS_WIDTH-1:0] m_data;

    modport master (
        input  start, s_valid, s_data, dsp_dout, m_ready,
        output busy, done, s_ready, dsp_din, dsp_we, dsp_param, m_valid, m_data
    );

    modport slave (
        output start, s_valid, s_data, dsp_dout, m_ready,
        input  busy, done, s_ready, dsp_din, dsp_we, dsp_param, m_valid, m_data
    );

endinterface

// File: rtl/dsp_frame_sequencer.sv
// Loads SLOTS words into the dsp shift register, then reads them back oldest first.
// The output register is a one-entry holding stage, held until the sink accepts.
module dsp_frame_sequencer
    import dsp_frame_sequencer_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int SLOTS     = SLOTS_DEF,
    parameter int PARAM_W   = PARAM_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    dsp_frame_sequencer_if.master bus
);

    if (CNT_W != $clog2(SLOTS + 1)) begin : g_bad_cnt_w
        $error("CNT_W does not match SLOTS");
    end
    if (DSP_READ_LAT != 2) begin : g_bad_read_lat
        $error("ADDR/WAITD sequencing assumes a 2-cycle dsp read latency");
    end
    if (SLOTS < 1 || (SLOTS - 1) >= (1 << PARAM_W)) begin : g_bad_param_w
        $error("SLOTS-1 must fit in PARAM_W bits");
    end

    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     wcnt;
    logic [CNT_W-1:0]     ridx;
    logic [BUS_WIDTH-1:0] din_q;
    logic                 we_q;
    logic [PARAM_W-1:0]   param_q;
    logic                 m_valid_q;
    logic [BUS_WIDTH-1:0] m_data_q;
    logic                 done_q;

    logic s_hs;
    logic last_wr;
    logic start_ok;
    logic accept;

    // A start in the done cycle is dropped even though the state is already IDLE.
    assign start_ok = (state == IDLE) && bus.start && !done_q;
    assign s_hs     = (state == LOAD) && bus.s_valid;
    assign last_wr  = s_hs && (wcnt == CNT_W'(SLOTS - 1));
    assign accept   = (state == OUT) && bus.m_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_nx unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = LOAD;
            LOAD:    if (last_wr)  state_nx = SETTLE;
            SETTLE:  state_nx = ADDR;
            ADDR:    state_nx = WAITD;
            WAITD:   state_nx = OUT;
            OUT:     if (accept) state_nx = (ridx == '0) ? IDLE : ADDR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt      <= '0;
            ridx      <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            param_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) wcnt <= '0;
                end
                LOAD: begin
                    if (s_hs) begin
                        din_q <= bus.s_data;
                        we_q  <= 1'b1;
                        wcnt  <= wcnt + 1'b1;
                    end
                end
                SETTLE: begin
                    // Oldest word sits in the highest slot, so reading starts there.
                    ridx    <= CNT_W'(SLOTS - 1);
                    param_q <= PARAM_W'(SLOTS - 1);
                end
                WAITD: begin
                    m_data_q  <= bus.dsp_dout;
                    m_valid_q <= 1'b1;
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        if (ridx != '0) begin
                            ridx    <= ridx - 1'b1;
                            param_q <= PARAM_W'(ridx - 1'b1);
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.s_ready   = (state == LOAD);
    assign bus.done      = done_q;
    assign bus.dsp_din   = din_q;
    assign bus.dsp_we    = we_q;
    assign bus.dsp_param = param_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;

endmodule
